// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and constants for the bit-serial adder
//               controller: FSM state encoding and default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Request/response bundle of the bit-serial adder.
//               master : requester (drives start/A/B/Cin, observes results)
//               slave  : adder controller
//   start      request a new addition
//   A, B, Cin  operands, captured on an accepted start
//   busy       addition in progress
//   done       one-cycle result-valid pulse
//   sum, carry registered result, held until the next completion
//   ovf        signed overflow flag (only with SERIAL_ADD_OVF_EN defined)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, A, B, Cin, input busy, done, sum, carry, ovf);
  modport slave  (input start, A, B, Cin, output busy, done, sum, carry, ovf);
`else
  modport master (output start, A, B, Cin, input busy, done, sum, carry);
  modport slave  (input start, A, B, Cin, output busy, done, sum, carry);
`endif

endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : 1-bit full adder cell, the bit-slice datapath of the serial
//               adder.
//   a, b, cin  addend bits and carry-in
//   s, cout    sum bit and carry-out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. Adds two WIDTH-bit operands one
//               bit per clock (LSB first) through a single full_adder cell,
//               with a start/busy/done handshake.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_add_ctrl_if.slave (start, A, B, Cin, busy, done, sum,
//          carry, and ovf when SERIAL_ADD_OVF_EN is defined)
// Optional feature macro: SERIAL_ADD_OVF_EN (registered signed overflow flag)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic               load;
  logic               last;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  // Only WIDTH-1 result bits need storage; the final bit comes straight
  // from the cell on the completing edge.
  logic [WIDTH-2:0]   s_sh;
  logic [WIDTH-1:0]   s_cat;
  logic               c_q;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;

  logic               fa_s;
  logic               fa_co;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // New sum bit enters at the MSB; the full concatenation is the result
  // once the last bit has been produced.
  assign s_cat = {fa_s, s_sh};
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Restart directly from DONE so held start gives no idle bubble.
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (load) begin
      a_sh <= bus.A;
      b_sh <= bus.B;
      c_q  <= bus.Cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= s_cat[WIDTH-1:1];
      c_q  <= fa_co;
      cnt  <= cnt + 1'b1;
      if (last) begin
        sum_q   <= s_cat;
        carry_q <= fa_co;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // c_q is the carry into the MSB while the last bit is processed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last && !load) begin
      ovf_q <= c_q ^ fa_co;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH=8). Expected
//               results come from plain integer addition of the operands.
//               Covers ovf when SERIAL_ADD_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] prev_sum   = '0;
  logic         prev_carry = 1'b0;
  logic         prev_ovf   = 1'b0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".busy"},  64'(bus.busy),  64'd0);
    check({tag, ".done"},  64'(bus.done),  64'd0);
    check({tag, ".sum"},   64'(bus.sum),   64'd0);
    check({tag, ".carry"}, 64'(bus.carry), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, ".ovf"},   64'(bus.ovf),   64'd0);
`endif
  endtask

  // Called at a negedge; returns at the negedge following the done edge.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit mid_start);
    logic [W:0]   total;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
    logic         exp_ovf;
    total     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_sum   = total[W-1:0];
    exp_carry = total[W];
    exp_ovf   = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);

    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("run.busy",  64'(bus.busy),  64'd1);
      check("run.done",  64'(bus.done),  64'd0);
      check("run.sum_held",   64'(bus.sum),   64'(prev_sum));
      check("run.carry_held", 64'(bus.carry), 64'(prev_carry));
      // Operands may wander during RUN; a mid-run start must be ignored.
      bus.A   = W'($urandom);
      bus.B   = W'($urandom);
      bus.Cin = 1'($urandom);
      bus.start = (mid_start && i == 2);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("end.done",  64'(bus.done),  64'd1);
    check("end.busy",  64'(bus.busy),  64'd0);
    check("end.sum",   64'(bus.sum),   64'(exp_sum));
    check("end.carry", 64'(bus.carry), 64'(exp_carry));
`ifdef SERIAL_ADD_OVF_EN
    check("end.ovf",   64'(bus.ovf),   64'(exp_ovf));
`endif
    prev_sum   = exp_sum;
    prev_carry = exp_carry;
    prev_ovf   = exp_ovf;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle.done", 64'(bus.done), 64'd0);
    check("idle.busy", 64'(bus.busy), 64'd0);
    check("idle.sum",  64'(bus.sum),  64'(prev_sum));
  endtask

  task automatic reset_mid_op();
    bus.start = 1'b1;
    bus.A     = 8'hA5;
    bus.B     = 8'h5A;
    bus.Cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("rst_mid.no_done", 64'(bus.done), 64'd0);
    end
    rst_n = 1'b1;
    prev_sum   = '0;
    prev_carry = 1'b0;
    prev_ovf   = 1'b0;
    idle_cycle();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs_zero("post_reset");

    do_add(8'h3C, 8'h2A, 1'b0, 1'b0);
    idle_cycle();
    do_add(8'hFF, 8'h01, 1'b0, 1'b0);
    idle_cycle();
    do_add(8'hFF, 8'hFF, 1'b1, 1'b0);
    idle_cycle();

    // Ignored start mid-run, then back-to-back with start held.
    do_add(8'h12, 8'h34, 1'b0, 1'b1);
    do_add(8'h7F, 8'h01, 1'b0, 1'b0);
    do_add(8'h80, 8'h80, 1'b0, 1'b0);
    do_add(8'h01, 8'h01, 1'b0, 1'b0);
    idle_cycle();

    reset_mid_op();
    do_add(8'h10, 8'h20, 1'b0, 1'b0);
    idle_cycle();

    for (int k = 0; k < 24; k++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
